// File: rtl/zet_wb_switch.sv
// Wishbone single-master, N-slave switch for the Zet SoC. It provides registered window decode,
// data/ack muxing, a bus watchdog and the POST capture register.
module zet_wb_switch #(
    parameter int unsigned        NSLV      = 4,
    parameter logic [8*NSLV-1:0]  MEM_BASE  = {NSLV{8'h00}},
    parameter logic [8*NSLV-1:0]  MEM_MASK  = {NSLV{8'h00}},
    parameter logic [8*NSLV-1:0]  IO_BASE   = {NSLV{8'h00}},
    parameter logic [8*NSLV-1:0]  IO_MASK   = {NSLV{8'h00}},
    parameter int unsigned        MEM_DEF   = NSLV - 1,
    parameter int unsigned        TIMEOUT   = 255,
    parameter logic [7:0]         POST_PORT = 8'hF1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [15:0]          m_dat_i,
    output logic [15:0]          m_dat_o,
    input  logic [19:1]          m_adr_i,
    input  logic                 m_we_i,
    input  logic                 m_tga_i,
    input  logic                 m_stb_i,
    input  logic                 m_cyc_i,
    input  logic [1:0]           m_sel_i,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    output logic [15:0]          s_dat_o,
    output logic [19:1]          s_adr_o,
    output logic                 s_we_o,
    output logic                 s_tga_o,
    output logic [1:0]           s_sel_o,
    input  logic [NSLV*16-1:0]   s_dat_i,
    output logic [NSLV-1:0]      s_stb_o,
    output logic [NSLV-1:0]      s_cyc_o,
    input  logic [NSLV-1:0]      s_ack_i,
    output logic [15:0]          post_o,
    output logic                 busy_o
);

    localparam int unsigned     WD_W     = 16;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [NSLV-1:0] DEF_SEL  = NSLV'(1) << MEM_DEF;

    typedef enum logic [1:0] {ST_IDLE, ST_ACT, ST_DFLT, ST_ERR} state_t;

    state_t            state_q, state_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [15:0]       post_d;
    logic [NSLV-1:0]   mem_hit, io_hit, hit, first_hit, dec_sel;
    logic [15:0]       act_dat;
    logic              ack, err;

    assign s_dat_o = m_dat_i;
    assign s_adr_o = m_adr_i;
    assign s_we_o  = m_we_i;
    assign s_tga_o = m_tga_i;
    assign s_sel_o = m_sel_i;
    assign busy_o  = (state_q != ST_IDLE);
    assign s_cyc_o = s_stb_o;

    // Window decode; the lowest-index hit wins, and unclaimed memory goes to the default slave.
    always_comb begin
        mem_hit = '0;
        io_hit  = '0;
        for (int k = 0; k < NSLV; k++) begin
            mem_hit[k] = (MEM_MASK[8*k+:8] != 8'h00) &&
                         ((m_adr_i[19:12] & MEM_MASK[8*k+:8]) == (MEM_BASE[8*k+:8] & MEM_MASK[8*k+:8]));
            io_hit[k]  = (IO_MASK[8*k+:8] != 8'h00) &&
                         ((m_adr_i[15:8] & IO_MASK[8*k+:8]) == (IO_BASE[8*k+:8] & IO_MASK[8*k+:8]));
        end
        hit       = m_tga_i ? io_hit : mem_hit;
        first_hit = hit & (~hit + NSLV'(1));
        if (|hit)
            dec_sel = first_hit;
        else
            dec_sel = m_tga_i ? '0 : DEF_SEL;
    end

    // Read-data mux over the frozen one-hot select.
    always_comb begin
        act_dat = '0;
        for (int k = 0; k < NSLV; k++)
            if (sel_q[k])
                act_dat = act_dat | s_dat_i[16*k+:16];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            wdog_q  <= '0;
            post_o  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wdog_q  <= wdog_d;
            post_o  <= post_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wdog_d  = wdog_q;
        post_d  = post_o;
        ack     = 1'b0;
        err     = 1'b0;
        m_dat_o = 16'h0000;
        s_stb_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                sel_d  = '0;
                if (m_stb_i && m_cyc_i) begin
                    sel_d   = dec_sel;
                    state_d = (m_tga_i && !(|io_hit)) ? ST_DFLT : ST_ACT;
                end
            end
            ST_ACT: begin
                s_stb_o = sel_q & {NSLV{m_stb_i & m_cyc_i}};
                m_dat_o = act_dat;
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    ack = |(s_ack_i & sel_q);
                    // A late ack beats the watchdog in its final cycle.
                    if (ack)
                        state_d = ST_IDLE;
                    else if (wdog_q == WD_LIMIT)
                        state_d = ST_ERR;
                    else
                        wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_DFLT: begin
                ack     = m_cyc_i;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                ack     = m_cyc_i;
                err     = m_cyc_i;
                m_dat_o = m_cyc_i ? 16'hFFFF : 16'h0000;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (m_tga_i && m_we_i && ack && !err && (m_adr_i[15:8] == POST_PORT)) begin
            if (m_sel_i[0]) post_d[7:0]  = m_dat_i[7:0];
            if (m_sel_i[1]) post_d[15:8] = m_dat_i[15:8];
        end
        m_ack_o = ack;
        m_err_o = err;
    end

endmodule
